// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register target.
package spi_reg_pkg;
    localparam int CMD_WRITE_BIT = 7;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WRITE,
        ST_READ
    } state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end

    assign q    = sync[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/spi_reg_target.sv
// SPI mode-0 target: oversampled byte frames become register-bus strobes.
module spi_reg_target
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              spi_clock_i,
    input  logic              spi_cs_i,
    input  logic              spi_pico_i,
    output logic              spi_poci_o,
    output logic              spi_poci_oeb_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              reg_wr_en_o,
    output logic              reg_rd_en_o,
    input  logic [DATA_W-1:0] reg_rdata_i,
    output logic              busy_o
);
    logic sck_level_unused, sck_rise, sck_fall;
    logic cs_q, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] pico_sync;
    logic pico_q;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .d    (spi_clock_i),
        .q    (sck_level_unused),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .d    (spi_cs_i),
        .q    (cs_q),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) pico_sync <= '0;
        else          pico_sync <= {pico_sync[SYNC_STAGES-2:0], spi_pico_i};
    end
    assign pico_q = pico_sync[SYNC_STAGES-1];

    state_t state, state_next;
    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] rx, tx, rx_byte;
    logic              rd_pend, skip_shift, byte_done;

    assign rx_byte   = {rx[DATA_W-2:0], pico_q};
    assign byte_done = sck_rise && (bit_cnt == 3'd7) && !cs_rise;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= ST_IDLE;
        else          state <= state_next;
    end

    // CS rise wins over any SCK edge seen in the same cycle
    always_comb begin
        state_next = state;
        if (cs_rise) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (cs_fall) state_next = ST_CMD;
                ST_CMD: begin
                    if (byte_done)
                        state_next = rx_byte[CMD_WRITE_BIT] ? ST_WRITE : ST_READ;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            bit_cnt     <= '0;
            rx          <= '0;
            tx          <= '0;
            rd_pend     <= 1'b0;
            skip_shift  <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_wr_en_o <= 1'b0;
            reg_rd_en_o <= 1'b0;
        end else begin
            reg_wr_en_o <= 1'b0;
            reg_rd_en_o <= 1'b0;
            rd_pend     <= reg_rd_en_o;
            if (reg_wr_en_o) reg_addr_o <= reg_addr_o + 1'b1;
            if (cs_rise) begin
                bit_cnt    <= '0;
                rx         <= '0;
                tx         <= '0;
                skip_shift <= 1'b0;
                rd_pend    <= 1'b0;
            end else if (state == ST_IDLE) begin
                bit_cnt <= '0;
                rx      <= '0;
            end else begin
                if (sck_rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    rx      <= rx_byte;
                end
                // first fall after a byte boundary keeps the fresh MSB on POCI
                if (sck_fall) begin
                    if (skip_shift) skip_shift <= 1'b0;
                    else            tx <= {tx[DATA_W-2:0], 1'b0};
                end
                if (rd_pend) begin
                    tx         <= reg_rdata_i;
                    reg_addr_o <= reg_addr_o + 1'b1;
                end
                if (byte_done) begin
                    case (state)
                        ST_CMD: begin
                            reg_addr_o <= rx_byte[ADDR_W-1:0];
                            if (!rx_byte[CMD_WRITE_BIT]) begin
                                reg_rd_en_o <= 1'b1;
                                skip_shift  <= 1'b1;
                            end
                        end
                        ST_WRITE: begin
                            reg_wr_en_o <= 1'b1;
                            reg_wdata_o <= rx_byte;
                        end
                        ST_READ: begin
                            reg_rd_en_o <= 1'b1;
                            skip_shift  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign spi_poci_o     = tx[DATA_W-1];
    assign spi_poci_oeb_o = cs_q;
    assign busy_o         = ~cs_q;
endmodule

// File: tb/tb_spi_reg_target.sv
// Scoreboard bench: expected strobes are queued by stimulus, checked by a monitor.
module tb_spi_reg_target;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       cs = 1'b1;
    logic       pico = 1'b0;
    logic       poci, oeb, wr_en, rd_en, busy;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata = 8'h00;

    typedef struct packed {
        logic       wr;
        logic [6:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] mem [128];

    spi_reg_target #(.SYNC_STAGES(2)) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .spi_clock_i    (sck),
        .spi_cs_i       (cs),
        .spi_pico_i     (pico),
        .spi_poci_o     (poci),
        .spi_poci_oeb_o (oeb),
        .reg_addr_o     (addr),
        .reg_wdata_o    (wdata),
        .reg_wr_en_o    (wr_en),
        .reg_rd_en_o    (rd_en),
        .reg_rdata_i    (rdata),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    // register model: read data valid one cycle after the strobe
    always @(posedge clk) if (rd_en) rdata <= mem[addr];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (wr_en || rd_en)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: wr=%0b rd=%0b addr=%0h",
                         wr_en, rd_en, addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_kind", {31'd0, wr_en}, {31'd0, e.wr});
                check("strobe_addr", {25'd0, addr}, {25'd0, e.addr});
                if (e.wr) check("strobe_wdata", {24'd0, wdata}, {24'd0, e.data});
            end
        end
    end

    task automatic clks(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n,
                            output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            pico = b[i];
            clks(10);
            sck = 1'b1;
            r[i] = poci;
            clks(10);
            sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        spi_bits(b, 8, r);
    endtask

    task automatic cs_begin();
        cs = 1'b0;
        clks(10);
    endtask

    task automatic cs_end();
        clks(10);
        cs = 1'b1;
        clks(20);
    endtask

    task automatic push(logic wr, logic [6:0] a, logic [7:0] d);
        exp_t e;
        e.wr = wr;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_wr"},    {31'd0, wr_en}, 0);
        check({tag, "_rd"},    {31'd0, rd_en}, 0);
        check({tag, "_addr"},  {25'd0, addr}, 0);
        check({tag, "_wdata"}, {24'd0, wdata}, 0);
        check({tag, "_poci"},  {31'd0, poci}, 0);
        check({tag, "_oeb"},   {31'd0, oeb}, 1);
        check({tag, "_busy"},  {31'd0, busy}, 0);
    endtask

    initial begin
        logic [7:0] r;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[16] = 8'h11;
        mem[17] = 8'h22;

        #23;
        check_reset_vals("reset");
        rst = 1'b0;
        clks(5);

        // write burst
        cs_begin();
        push(1'b1, 7'h05, 8'hA5);
        push(1'b1, 7'h06, 8'h3C);
        spi_byte(8'h85, r);
        check("busy_active", {31'd0, busy}, 1);
        check("oeb_active", {31'd0, oeb}, 0);
        spi_byte(8'hA5, r);
        check("poci_write", {24'd0, r}, 0);
        spi_byte(8'h3C, r);
        cs_end();

        // read burst: one read per byte boundary, including the last
        cs_begin();
        push(1'b0, 7'h10, 8'h00);
        push(1'b0, 7'h11, 8'h00);
        push(1'b0, 7'h12, 8'h00);
        spi_byte(8'h10, r);
        check("poci_cmd", {24'd0, r}, 0);
        spi_byte(8'h00, r);
        check("poci_rd0", {24'd0, r}, 32'h11);
        spi_byte(8'h00, r);
        check("poci_rd1", {24'd0, r}, 32'h22);
        cs_end();

        // address wrap
        cs_begin();
        push(1'b1, 7'h7F, 8'hAA);
        push(1'b1, 7'h00, 8'h55);
        spi_byte(8'hFF, r);
        spi_byte(8'hAA, r);
        spi_byte(8'h55, r);
        cs_end();

        // abort after 5 bits of a data byte
        cs_begin();
        spi_byte(8'h83, r);
        spi_bits(8'hF0, 5, r);
        cs = 1'b1;
        clks(20);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_oeb", {31'd0, oeb}, 1);
        check("abort_poci", {31'd0, poci}, 0);
        cs_begin();
        push(1'b1, 7'h04, 8'h5A);
        spi_byte(8'h84, r);
        spi_byte(8'h5A, r);
        cs_end();

        // reset in the middle of a read frame
        cs_begin();
        push(1'b0, 7'h20, 8'h00);
        spi_byte(8'h20, r);
        spi_bits(8'h00, 4, r);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        cs = 1'b1;
        sck = 1'b0;
        clks(5);
        rst = 1'b0;
        clks(10);
        cs_begin();
        push(1'b1, 7'h05, 8'h77);
        spi_byte(8'h85, r);
        spi_byte(8'h77, r);
        cs_end();

        // SCK activity with CS high
        for (int i = 0; i < 10; i++) begin
            pico = 1'($urandom_range(0, 1));
            clks(10);
            sck = ~sck;
        end
        check("idle_busy", {31'd0, busy}, 0);
        check("idle_oeb", {31'd0, oeb}, 1);
        clks(20);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
